// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver FSM state encoding and parity helper
// Used by uart_rx_param now and by the parametrised transmitter later.
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;
   localparam logic [2:0] ST_WAIT  = 3'd5;
   // Parity bit to transmit/expect for data d (zero-extended to 9 bits).
   // Odd: data plus parity bit holds an odd number of ones.
   function automatic logic parity_bit(input logic [8:0] d, input int mode);
      return (mode == PAR_ODD) ? ~^d : ^d;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser with falling-edge detect
// Ports: clk, rst_n (async active-low), din (async input),
//        dout (synchronised level, resets to 1), fall (1->0 transition flag).
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic fall
);
   logic s1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, dout} <= 2'b11;
      else        {s1, dout} <= {din, s1};
   // Flags the cycle before dout drops, so a timer cleared on fall starts
   // counting exactly on the first low cycle of dout.
   assign fall = dout & ~s1;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority vote and valid/ready output
// Ports: clk, rst_n (async active-low), rx (async serial in, idle high),
//        data_out/data_valid/data_ready (word handshake), frame_err/parity_err
//        (qualify data_out), overrun (pulse on dropped frame), busy (FSM not idle).
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 2500,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int H  = CLK_DIV / 2;
   localparam int TW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_HM1  = TW'(H - 1);
   localparam logic [TW-1:0] T_H    = TW'(H);
   localparam logic [TW-1:0] T_HP1  = TW'(H + 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

   logic                 rx_s, fall;
   logic [2:0]           state;
   logic [TW-1:0]        tick;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 sa, sb, ferr_acc, perr_r;
   logic                 vote, at_vote, wrap, last_stop, complete, load;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (rx),
      .dout (rx_s),
      .fall (fall)
   );

   // Third sample is rx_s itself, so the vote is valid on the H+1 tick.
   assign vote      = (sa & sb) | (sa & rx_s) | (sb & rx_s);
   assign at_vote   = tick == T_HP1;
   assign wrap      = tick == T_LAST;
   assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
   assign complete  = (state == ST_STOP) && at_vote && last_stop;
   assign load      = complete && (!data_valid || data_ready);
   assign busy      = state != ST_IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= ST_IDLE;
         tick     <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         sa       <= 1'b1;
         sb       <= 1'b1;
         ferr_acc <= 1'b0;
         perr_r   <= 1'b0;
      end else begin
         tick <= (state == ST_IDLE || state == ST_WAIT || wrap) ? '0 : tick + 1'b1;
         if (tick == T_HM1) sa <= rx_s;
         if (tick == T_H)   sb <= rx_s;
         case (state)
            ST_IDLE:
               if (fall) begin
                  state    <= ST_START;
                  ferr_acc <= 1'b0;
                  perr_r   <= 1'b0;
               end
            ST_START:
               if (at_vote && vote) state <= ST_IDLE;
               else if (wrap) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
               end
            ST_DATA: begin
               if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
               if (wrap) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     state    <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                     stop_cnt <= 1'b0;
                  end
               end
            end
            ST_PAR: begin
               if (at_vote) perr_r <= vote != parity_bit(9'(shreg), PARITY);
               if (wrap) state <= ST_STOP;
            end
            ST_STOP: begin
               if (at_vote && !vote) ferr_acc <= 1'b1;
               // A low final stop bit means the line may be held low (break);
               // park in WAIT until it returns high to avoid retriggering.
               if (complete) state <= vote ? ST_IDLE : ST_WAIT;
               else if (wrap) stop_cnt <= stop_cnt + 1'b1;
            end
            ST_WAIT:
               if (rx_s) state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         data_valid <= load | (data_valid & ~data_ready);
         overrun    <= complete & ~load;
         if (load) begin
            data_out   <= shreg;
            frame_err  <= ferr_acc | ~vote;
            parity_err <= (PARITY != PAR_NONE) & perr_r;
         end
      end
endmodule
